// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL / PSRAM reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST    = 2'd0,
    WAIT_LOCK  = 2'd1,
    PSRAM_INIT = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int CTR_W = 8;
  localparam logic [CTR_W-1:0] CTR_MAX = 8'hFF;

  // Event counters stick at CTR_MAX instead of wrapping.
  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
    return (v == CTR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Multi-flop synchronizer for one asynchronous level signal; q resets to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL / PSRAM / system reset sequencer running on the crystal clock.
// Optional lock-loss counter port enabled by defining PLL_RST_SEQ_LOSS_CNT_EN.
import pll_rst_seq_pkg::*;

module pll_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int CALIB_TIMEOUT  = 16384,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_done,
  output logic       pll_rst,
  output logic       psram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_cnt,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);

  logic lock_s, cal_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cal (
    .clk (clk),
    .rst (rst),
    .d   (calib_done),
    .q   (cal_s)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic             retry_inc;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    tcnt_nxt  = tcnt + 1'b1;
    retry_inc = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A completed stability window beats a timeout landing on the same cycle.
        if (lock_s && cnt == STABLE_LAST) begin
          state_nxt = PSRAM_INIT;
        end else if (tcnt == LOCK_LAST) begin
          state_nxt = PLL_RST;
          retry_inc = 1'b1;
        end else if (!lock_s) begin
          cnt_nxt = '0;
        end
      end
      PSRAM_INIT: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
        end else if (cal_s) begin
          state_nxt = RUN;
        end else if (cnt == CALIB_LAST) begin
          state_nxt = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = PLL_RST;
      end
      default: state_nxt = PLL_RST;
    endcase
    if (state_nxt != state) begin
      cnt_nxt  = '0;
      tcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      tcnt      <= '0;
      pll_rst   <= 1'b1;
      psram_rst <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tcnt      <= tcnt_nxt;
      // Outputs decode the state being entered so they change on the transition edge.
      pll_rst   <= (state_nxt == PLL_RST);
      psram_rst <= !(state_nxt == PSRAM_INIT || state_nxt == RUN);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      if (retry_inc) retry_cnt <= sat_inc(retry_cnt);
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // RUN is only ever left because lock dropped.
  always_ff @(posedge clk) begin
    if (rst)                                     lock_loss_cnt <= '0;
    else if (state == RUN && state_nxt == PLL_RST) lock_loss_cnt <= sat_inc(lock_loss_cnt);
  end
`endif

  assign dbg_state = state;

endmodule
